// File: rtl/csel_subtractor_seq.sv
// Sequential carry-select subtractor: D = A - B - bin, one 4-bit slice per clock.
// Define CSEL_SUB_OVF_EN to add the signed-overflow output ovf.
module csel_subtractor_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef CSEL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int SLICES = WIDTH / 4;
   localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
         $error("csel_subtractor_seq: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] nb_q;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W+1:0] base;
   logic [3:0]       a_sl, nb_sl;
   logic [4:0]       sum0, sum1, sel;
   logic             last_slice;

   assign base       = {cnt, 2'b00};
   assign last_slice = (cnt == LAST);

   // Both carry-in cases are formed in parallel; the registered carry picks one.
   always_comb begin
      a_sl  = a_q[base +: 4];
      nb_sl = nb_q[base +: 4];
      sum0  = {1'b0, a_sl} + {1'b0, nb_sl};
      sum1  = {1'b0, a_sl} + {1'b0, nb_sl} + 5'd1;
      sel   = carry ? sum1 : sum0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = RUN;
         RUN:     if (last_slice) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Subtraction as a + ~b + ~bin, so the borrow chain is an inverted carry chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         nb_q  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         diff  <= '0;
         bout  <= 1'b0;
`ifdef CSEL_SUB_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  nb_q  <= ~b;
                  carry <= ~bin;
                  cnt   <= '0;
                  diff  <= '0;
                  bout  <= 1'b0;
`ifdef CSEL_SUB_OVF_EN
                  ovf   <= 1'b0;
`endif
               end
            end
            RUN: begin
               diff[base +: 4] <= sel[3:0];
               carry           <= sel[4];
               if (last_slice) begin
                  cnt  <= '0;
                  bout <= ~sel[4];
`ifdef CSEL_SUB_OVF_EN
                  // Carry into the top bit is recovered from its sum bit and operands.
                  ovf  <= sel[4] ^ (sel[3] ^ a_sl[3] ^ nb_sl[3]);
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_csel_subtractor_seq.sv
// Self-checking bench for csel_subtractor_seq (WIDTH=16): directed cases plus
// randomized operations compared against an integer-arithmetic reference.
module tb_csel_subtractor_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         bin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, bout;
   logic [W-1:0] diff;
`ifdef CSEL_SUB_OVF_EN
   logic         ovf;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   csel_subtractor_seq #(.WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .bin(bin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .diff(diff),
      .bout(bout)
`ifdef CSEL_SUB_OVF_EN
      ,
      .ovf(ovf)
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed integer arithmetic on the operand values.
   function automatic logic [W-1:0] refDiff(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      longint r;
      r = longint'(x) - longint'(y) - longint'(c);
      return W'(r);
   endfunction

   function automatic logic refBout(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return (longint'(x) < longint'(y) + longint'(c));
   endfunction

   function automatic logic refOvf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      longint sx, sy, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = sx - sy - longint'(c);
      return (r > 32767) || (r < -32768);
   endfunction

   task automatic waitOutValid(output int edges);
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (!out_valid && edges < 50);
   endtask

   task automatic checkResult(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      checkOutput({tag, ":diff"}, 32'(diff), 32'(refDiff(x, y, c)));
      checkOutput({tag, ":bout"}, 32'(bout), 32'(refBout(x, y, c)));
`ifdef CSEL_SUB_OVF_EN
      checkOutput({tag, ":ovf"}, 32'(ovf), 32'(refOvf(x, y, c)));
`endif
   endtask

   // Starts at posedge+1 in IDLE; runs one full operation with a stall in DONE.
   task automatic applyStimulus(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic c, input int stall);
      int           edges;
      logic [W-1:0] held_diff;
      logic         held_bout;
      a = x;
      b = y;
      bin = c;
      in_valid = 1'b1;
      checkOutput({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      checkOutput({tag, ":in_ready_run"}, 32'(in_ready), 32'd0);
      waitOutValid(edges);
      checkOutput({tag, ":latency"}, 32'(edges), 32'(W / 4));
      checkResult(tag, x, y, c);
      held_diff = diff;
      held_bout = bout;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         checkOutput({tag, ":stall_valid"}, 32'(out_valid), 32'd1);
         checkOutput({tag, ":stall_ready"}, 32'(in_ready), 32'd0);
         checkOutput({tag, ":stall_diff"}, 32'(diff), 32'(held_diff));
         checkOutput({tag, ":stall_bout"}, 32'(bout), 32'(held_bout));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, ":post_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, ":post_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int edges;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset:out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset:in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset:diff", 32'(diff), 32'd0);
      checkOutput("reset:bout", 32'(bout), 32'd0);
      rst_n = 1'b1;

      applyStimulus("basic", 16'h1234, 16'h0234, 1'b0, 0);
      applyStimulus("wrap", 16'h0000, 16'h0001, 1'b0, 0);
      applyStimulus("eq_bin", 16'h0005, 16'h0005, 1'b1, 0);
      applyStimulus("ovf_neg", 16'h8000, 16'h0000, 1'b1, 0);
      applyStimulus("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 0);
      applyStimulus("backpressure", 16'hBEEF, 16'h1234, 1'b1, 5);

      // Back-to-back: in_valid stays high, second operand set waits for the handshake.
      a = 16'hA5A5;
      b = 16'h5A5A;
      bin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      a = 16'h0100;
      b = 16'h0200;
      bin = 1'b1;
      waitOutValid(edges);
      checkOutput("b2b1:latency", 32'(edges), 32'(W / 4));
      checkResult("b2b1", 16'hA5A5, 16'h5A5A, 1'b0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("b2b:idle_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("b2b2:accepted", 32'(in_ready), 32'd0);
      waitOutValid(edges);
      checkOutput("b2b2:latency", 32'(edges), 32'(W / 4));
      checkResult("b2b2", 16'h0100, 16'h0200, 1'b1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Reset while slice 2 is in progress.
      a = 16'hFFFF;
      b = 16'h1111;
      bin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      checkOutput("midreset:out_valid", 32'(out_valid), 32'd0);
      checkOutput("midreset:diff", 32'(diff), 32'd0);
      checkOutput("midreset:in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus("after_reset", 16'h00FF, 16'h0001, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         applyStimulus("random", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
